// File: rtl/tdp18k_init_loader_pkg.sv
// Shared types and helpers for the x18 RAM init/verify engines.
package tdp18k_init_loader_pkg;

    localparam int         CHK_W  = 18;
    localparam int         CNT_W  = 10;
    localparam int         ADDR_W = 14;
    localparam logic [1:0] BE_X18 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DRAIN,
        ST_READ,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Rotate-left-by-one then XOR in the new {parity, data} word.
    function automatic logic [CHK_W-1:0] chk18_fold(input logic [CHK_W-1:0] chk,
                                                    input logic [CHK_W-1:0] word);
        return {chk[CHK_W-2:0], chk[CHK_W-1]} ^ word;
    endfunction

endpackage

// File: rtl/tdp18k_init_loader_if.sv
// Stream, status and RAM-port signals of the init loader.
// master = loader side, slave = host/stream source plus attached RAM port.
interface tdp18k_init_loader_if;
    import tdp18k_init_loader_pkg::*;

    logic              START;
    logic              S_VALID;
    logic              S_READY;
    logic [15:0]       S_DATA;
    logic [1:0]        S_PARITY;
    logic              BUSY;
    logic              DONE;
    logic              PASS;
    logic              WEN;
    logic              REN;
    logic [1:0]        BE;
    logic [ADDR_W-1:0] ADDR;
    logic [15:0]       WDATA;
    logic [1:0]        WPARITY;
    logic [15:0]       RDATA;
    logic [1:0]        RPARITY;

    modport master (
        input  START, S_VALID, S_DATA, S_PARITY, RDATA, RPARITY,
        output S_READY, BUSY, DONE, PASS, WEN, REN, BE, ADDR, WDATA, WPARITY
    );

    modport slave (
        output START, S_VALID, S_DATA, S_PARITY, RDATA, RPARITY,
        input  S_READY, BUSY, DONE, PASS, WEN, REN, BE, ADDR, WDATA, WPARITY
    );

endinterface

// File: rtl/tdp18k_chk18.sv
// 18-bit rolling checksum register; clear wins over enable.
module tdp18k_chk18
    import tdp18k_init_loader_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CHK_W-1:0] i_word,
    output logic [CHK_W-1:0] o_chk
);

    logic [CHK_W-1:0] r_chk;

    // Accumulate one word per enabled cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_chk <= '0;
        end else if (i_en) begin
            r_chk <= chk18_fold(r_chk, i_word);
        end
    end

    assign o_chk = r_chk;

endmodule

// File: rtl/tdp18k_init_loader.sv
// Loads a streamed x18 image into one RAM port, reads it back and
// compares write-side and read-side rolling checksums.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for START, all outputs quiet
// ST_WRITE | S_READY high, each accepted beat becomes one registered write
// ST_DRAIN | last write visible on the port, counter cleared for readback
// ST_READ  | one read per cycle over the whole region
// ST_CHECK | last read word folded in, checksums compared
// ST_DONE  | DONE high, PASS held until next START
module tdp18k_init_loader
    import tdp18k_init_loader_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int ADDR_LSB = 4
) (
    input logic                  CLK,
    input logic                  RST,
    tdp18k_init_loader_if.master bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wen;
    logic               r_ren;
    logic               r_rd_pend;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_wdata;
    logic [1:0]         r_wpar;
    logic               r_sready;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    logic               w_start;
    logic               w_beat;
    logic [CHK_W-1:0]   w_wr_word;
    logic [CHK_W-1:0]   w_rd_word;
    logic [CHK_W-1:0]   w_wr_chk;
    logic [CHK_W-1:0]   w_rd_chk;

    function automatic logic [ADDR_W-1:0] idx2addr(input logic [CNT_W-1:0] idx);
        return ADDR_W'(idx) << ADDR_LSB;
    endfunction

    assign w_start   = bus.START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_beat    = bus.S_VALID && r_sready;
    assign w_wr_word = {bus.S_PARITY, bus.S_DATA};
    assign w_rd_word = {bus.RPARITY, bus.RDATA};

    tdp18k_chk18 u_wr_chk (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_clr  (w_start),
        .i_en   (w_beat),
        .i_word (w_wr_word),
        .o_chk  (w_wr_chk)
    );

    // Read data arrives the cycle after REN, so the read side folds on the delayed REN.
    tdp18k_chk18 u_rd_chk (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_clr  (w_start),
        .i_en   (r_rd_pend),
        .i_word (w_rd_word),
        .o_chk  (w_rd_chk)
    );

    // Sequencer with registered RAM-port and status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
            r_rd_pend <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wpar    <= '0;
            r_sready  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
            r_rd_pend <= r_ren;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_state  <= ST_WRITE;
                        r_cnt    <= '0;
                        r_addr   <= '0;
                        r_sready <= 1'b1;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (w_beat) begin
                        r_wen   <= 1'b1;
                        r_addr  <= idx2addr(r_cnt);
                        r_wdata <= bus.S_DATA;
                        r_wpar  <= bus.S_PARITY;
                        r_cnt   <= r_cnt + 10'd1;
                        if (r_cnt == LAST) begin
                            r_state  <= ST_DRAIN;
                            r_sready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_READ;
                    r_cnt   <= '0;
                    r_ren   <= 1'b1;
                    r_addr  <= '0;
                end
                ST_READ: begin
                    if (r_cnt == LAST) begin
                        r_state <= ST_CHECK;
                        r_addr  <= '0;
                    end else begin
                        r_ren  <= 1'b1;
                        r_cnt  <= r_cnt + 10'd1;
                        r_addr <= idx2addr(r_cnt + 10'd1);
                    end
                end
                ST_CHECK: begin
                    // Compare against the read sum including the word arriving this cycle.
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_wr_chk == chk18_fold(w_rd_chk, w_rd_word));
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.S_READY = r_sready;
    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;
    assign bus.PASS    = r_pass;
    assign bus.WEN     = r_wen;
    assign bus.REN     = r_ren;
    assign bus.BE      = BE_X18;
    assign bus.ADDR    = r_addr;
    assign bus.WDATA   = r_wdata;
    assign bus.WPARITY = r_wpar;

endmodule
